// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing generator.
// Free-running pixel divider plus HCount/VCount pixel counters. hsync, vsync and
// video_on are registered from the next counter values, so they line up with
// the counters they describe. pix_tick, vblank_start and frame_end are decoded
// combinationally from the current state.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       vblank_start,
  output logic       frame_end
);

  // Both totals are expected to fit in the 10-bit counters.
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  // One spare bit so the divider never compares against its own maximum value.
  localparam int DIV_W    = $clog2(CLK_DIV) + 1;

  logic [DIV_W-1:0] div_cnt_r;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;
  logic             hsync_r;
  logic             vsync_r;
  logic             video_on_r;
  logic             pix_tick_s;
  logic             h_last_s;

  assign pix_tick_s = (div_cnt_r == DIV_W'(CLK_DIV - 1));
  assign h_last_s   = (h_cnt_r == 10'(H_TOTAL - 1));

  // Pixel-rate divider: counts 0..CLK_DIV-1; any out-of-range value returns to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (pix_tick_s || (div_cnt_r > DIV_W'(CLK_DIV - 1))) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Next raster position; values at or beyond the total wrap to 0 on the next tick.
  always_comb begin
    h_next_s = h_cnt_r;
    v_next_s = v_cnt_r;
    if (pix_tick_s) begin
      if (h_cnt_r >= 10'(H_TOTAL - 1)) begin
        h_next_s = 10'd0;
        if (v_cnt_r >= 10'(V_TOTAL - 1)) begin
          v_next_s = 10'd0;
        end else begin
          v_next_s = v_cnt_r + 10'd1;
        end
      end else begin
        h_next_s = h_cnt_r + 10'd1;
        v_next_s = v_cnt_r;
      end
    end else begin
      h_next_s = h_cnt_r;
      v_next_s = v_cnt_r;
    end
  end

  // Raster counters and the sync/visible flags derived from the next position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_r    <= 10'd0;
      v_cnt_r    <= 10'd0;
      hsync_r    <= 1'b1;
      vsync_r    <= 1'b1;
      video_on_r <= 1'b1;
    end else begin
      h_cnt_r    <= h_next_s;
      v_cnt_r    <= v_next_s;
      hsync_r    <= !((h_next_s >= 10'(HS_START)) && (h_next_s < 10'(HS_END)));
      vsync_r    <= !((v_next_s >= 10'(VS_START)) && (v_next_s < 10'(VS_END)));
      video_on_r <= (h_next_s < 10'(H_DISPLAY)) && (v_next_s < 10'(V_DISPLAY));
    end
  end

  assign pix_tick     = pix_tick_s;
  assign HCount       = h_cnt_r;
  assign VCount       = v_cnt_r;
  assign hsync        = hsync_r;
  assign vsync        = vsync_r;
  assign video_on     = video_on_r;
  assign vblank_start = pix_tick_s && h_last_s && (v_cnt_r == 10'(V_DISPLAY - 1));
  assign frame_end    = pix_tick_s && h_last_s && (v_cnt_r == 10'(V_TOTAL - 1));

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three builds of the timing generator.
// The first two use a shrunken raster (23x11, with CLK_DIV of 2 and 1). The
// third uses the default 640x480 raster over its first lines. Expected outputs
// come from a position model: pixel index = (clocks since reset / CLK_DIV)
// mod frame size. Directed checks pin the strobes, the boundaries and a
// mid-frame reset to hand-computed values.
module tb_vga_timing_gen;

  localparam int HD = 16, HF = 2, HS = 3, HB = 2;  // H_TOTAL 23, hsync low 18..20
  localparam int VD = 6,  VF = 1, VS = 2, VB = 2;  // V_TOTAL 11, vsync low 7..8

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       pt0, hs0, vs0, von0, vb0, fe0;
  logic [9:0] h0, v0;
  logic       pt1, hs1, vs1, von1, vb1, fe1;
  logic [9:0] h1, v1;
  logic       ptd, hsd, vsd, vond, vbd, fed;
  logic [9:0] hd, vd;

  vga_timing_gen #(.CLK_DIV(2), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut0 (
    .clk(clk), .rst_n(rst_n), .pix_tick(pt0), .HCount(h0), .VCount(v0), .hsync(hs0),
    .vsync(vs0), .video_on(von0), .vblank_start(vb0), .frame_end(fe0));

  vga_timing_gen #(.CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_tick(pt1), .HCount(h1), .VCount(v1), .hsync(hs1),
    .vsync(vs1), .video_on(von1), .vblank_start(vb1), .frame_end(fe1));

  vga_timing_gen dutd (
    .clk(clk), .rst_n(rst_n), .pix_tick(ptd), .HCount(hd), .VCount(vd), .hsync(hsd),
    .vsync(vsd), .video_on(vond), .vblank_start(vbd), .frame_end(fed));

  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  longint t = 0;
  bit     mvalid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs {pix_tick, HCount, VCount, hsync, vsync, video_on, vblank_start, frame_end}
  // after tt clock edges since the last reset edge.
  function automatic logic [25:0] model(input int cd, input int hdisp, input int hf,
                                        input int hsw, input int hb, input int vdisp,
                                        input int vf, input int vsw, input int vb,
                                        input longint tt);
    int ht, vt, h, v;
    longint p;
    logic pt, hsy, vsy, von, vbl, fe;
    ht  = hdisp + hf + hsw + hb;
    vt  = vdisp + vf + vsw + vb;
    p   = (tt / cd) % (ht * vt);
    h   = int'(p % ht);
    v   = int'(p / ht);
    pt  = ((tt % cd) == cd - 1);
    hsy = !((h >= hdisp + hf) && (h < hdisp + hf + hsw));
    vsy = !((v >= vdisp + vf) && (v < vdisp + vf + vsw));
    von = (h < hdisp) && (v < vdisp);
    vbl = pt && (h == ht - 1) && (v == vdisp - 1);
    fe  = pt && (h == ht - 1) && (v == vt - 1);
    return {pt, 10'(h), 10'(v), hsy, vsy, von, vbl, fe};
  endfunction

  // Clocks elapsed since the last edge that sampled reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      t      <= 0;
      mvalid <= 1'b1;
    end else begin
      t <= t + 1;
    end
  end

  // Every-cycle comparison of all three builds against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      check("model_cd2", 32'({pt0, h0, v0, hs0, vs0, von0, vb0, fe0}),
            32'(model(2, HD, HF, HS, HB, VD, VF, VS, VB, t)));
      check("model_cd1", 32'({pt1, h1, v1, hs1, vs1, von1, vb1, fe1}),
            32'(model(1, HD, HF, HS, HB, VD, VF, VS, VB, t)));
      check("model_def", 32'({ptd, hd, vd, hsd, vsd, vond, vbd, fed}),
            32'(model(2, 640, 16, 96, 48, 480, 10, 2, 33, t)));
    end
  end

  // Frame period measurement between successive frame_end pulses.
  int fe_last0 = -1, fe_last1 = -1, np0 = 0, np1 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      fe_last0 = -1;
      fe_last1 = -1;
    end else begin
      if (fe0 === 1'b1) begin
        if (fe_last0 >= 0) begin
          check("fe_period_cd2", 32'(cyc - fe_last0), 32'd506);
          np0++;
        end
        fe_last0 = cyc;
      end
      if (fe1 === 1'b1) begin
        if (fe_last1 >= 0) begin
          check("fe_period_cd1", 32'(cyc - fe_last1), 32'd253);
          np1++;
        end
        fe_last1 = cyc;
      end
    end
  end

  bit found;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_h", 32'(h0), 32'd0);
    check("rst_v", 32'(v0), 32'd0);
    check("rst_hsync", 32'(hs0), 32'd1);
    check("rst_vsync", 32'(vs0), 32'd1);
    check("rst_video_on", 32'(von0), 32'd1);
    check("rst_tick_cd2", 32'(pt0), 32'd0);
    check("rst_tick_cd1", 32'(pt1), 32'd1);
    check("rst_strobes", 32'({vb0, fe0}), 32'd0);
    rst_n = 1'b1;

    // vblank_start on the last pixel of the last visible line
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (vb0 === 1'b1) found = 1'b1;
    end
    check("vblank_seen", 32'(found), 32'd1);
    check("vblank_pos", 32'({h0, v0}), {12'd0, 10'd22, 10'd5});
    check("vblank_tick", 32'(pt0), 32'd1);
    check("vblank_von", 32'(von0), 32'd0);
    @(negedge clk);
    check("vblank_width", 32'(vb0), 32'd0);
    check("post_vblank_pos", 32'({h0, v0}), {12'd0, 10'd0, 10'd6});

    // frame_end on the last pixel of the frame, then back to (0,0)
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (fe0 === 1'b1) found = 1'b1;
    end
    check("fe_seen", 32'(found), 32'd1);
    check("fe_pos", 32'({h0, v0}), {12'd0, 10'd22, 10'd10});
    check("fe_von", 32'(von0), 32'd0);
    @(negedge clk);
    check("fe_width", 32'(fe0), 32'd0);
    check("post_fe_pos", 32'({h0, v0}), 32'd0);
    check("post_fe_von", 32'(von0), 32'd1);

    // default raster: visible edge at 639/640 and hsync window 656..751
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (hd == 10'd639) found = 1'b1;
    end
    check("def_639_seen", 32'(found), 32'd1);
    check("def_639_von", 32'({vond, hsd, vd}), {21'd0, 1'b1, 1'b1, 10'd0});
    repeat (2) @(negedge clk);
    check("def_640_von", 32'({hd, vond}), {21'd0, 10'd640, 1'b0});
    repeat (30) @(negedge clk);
    check("def_655_hsync", 32'({hd, hsd}), {21'd0, 10'd655, 1'b1});
    repeat (2) @(negedge clk);
    check("def_656_hsync", 32'({hd, hsd}), {21'd0, 10'd656, 1'b0});
    repeat (190) @(negedge clk);
    check("def_751_hsync", 32'({hd, hsd}), {21'd0, 10'd751, 1'b0});
    repeat (2) @(negedge clk);
    check("def_752_hsync", 32'({hd, hsd}), {21'd0, 10'd752, 1'b1});

    // mid-frame reset at (10,4)
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (h0 == 10'd10 && v0 == 10'd4) found = 1'b1;
    end
    check("midrst_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pos", 32'({h0, v0}), 32'd0);
    check("midrst_flags", 32'({hs0, vs0, von0}), 32'd7);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel1_pos_tick", 32'({h0, pt0}), 32'd1);
    @(negedge clk);
    check("rel2_pos", 32'(h0), 32'd1);

    repeat (1100) @(negedge clk);
    check("fe_periods_cd2", 32'(np0 >= 3), 32'd1);
    check("fe_periods_cd1", 32'(np1 >= 3), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
